hazard_forward_ctrl: RTL and testbench

Hazard-detection and forwarding-select generator for the five-stage pipeline. It tracks the register writes in flight in the ID/EX, EX/MEM and MEM/WB stages, and drives the select codes consumed by the operand, compare, jump-target and store-data muxes. It also drives the ID stall that inserts a bubble into EX. An optional multiply/divide busy tracker stalls HI/LO consumers while the multi-cycle unit is working.

---
 rtl/hazard_forward_ctrl.sv | 169 ++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// Hazard detection and forwarding-select generator for the five-stage pipeline.
// Optional mult/div busy tracker enabled by defining HAZARD_MULDIV_EN.
module hazard_forward_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    localparam int unsigned AW = 5,
    localparam int unsigned KW = 2,
    localparam int unsigned SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_rs_use_d,
    input  logic          id_rt_use_d,
    input  logic          id_rs_use_e,
    input  logic          id_rt_use_e,
    input  logic [AW-1:0] id_wa,
    input  logic [KW-1:0] id_wkind,
    input  logic          id_md_use,
    input  logic          ex_md_start,
    input  logic          ex_md_div,
    output logic          stall,
    output logic [SW-1:0] cmp_src_rs,
    output logic [SW-1:0] cmp_src_rt,
    output logic [SW-1:0] alu_src_rs,
    output logic [SW-1:0] alu_src_rt,
    output logic [SW-1:0] dm_src,
    output logic          md_busy
);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] wa;
        logic [KW-1:0] kind;
    } trk_t;

    localparam logic [KW-1:0] K_LINK  = KW'(1);
    localparam logic [KW-1:0] K_LOAD  = KW'(3);
    localparam logic [SW-1:0] SEL_RF  = SW'(0);
    localparam logic [SW-1:0] SEL_EXM = SW'(1);
    localparam logic [SW-1:0] SEL_MWB = SW'(2);
    localparam logic [SW-1:0] SEL_PC8 = SW'(3);

    trk_t          e_q, m_q, w_q, e_d;
    logic [AW-1:0] e_rs_q, e_rt_q, e_rs_d, e_rt_d;
    logic          e_rs_use_q, e_rt_use_q, e_rs_use_d, e_rt_use_d;
    logic          rs_stall_c, rt_stall_c, lu_stall_c, md_stall_c;

    // Register $0 and empty slots never match.
    function automatic logic hit(input trk_t t, input logic [AW-1:0] a);
        return t.valid && (t.kind != '0) && (a != '0) && (t.wa == a);
    endfunction

    // ID-stage select: returns {stall, code}; youngest producer wins.
    function automatic logic [SW:0] id_fwd(input logic use_d, input logic [AW-1:0] a,
                                           input trk_t e, input trk_t m, input trk_t w);
        logic [SW:0] r;
        r = '0;
        if (use_d) begin
            if (hit(e, a)) begin
                r = (e.kind == K_LINK) ? {1'b0, SEL_PC8} : {1'b1, SEL_RF};
            end else if (hit(m, a)) begin
                r = (m.kind == K_LOAD) ? {1'b1, SEL_RF} : {1'b0, SEL_EXM};
            end else if (hit(w, a)) begin
                r = {1'b0, SEL_MWB};
            end
        end
        return r;
    endfunction

    // EX-stage select; a load in M cannot legally reach here, so it falls to 0.
    function automatic logic [SW-1:0] ex_fwd(input logic use_e, input logic [AW-1:0] a,
                                             input trk_t m, input trk_t w);
        logic [SW-1:0] r;
        r = SEL_RF;
        if (use_e) begin
            if (hit(m, a)) begin
                r = (m.kind == K_LOAD) ? SEL_RF : SEL_EXM;
            end else if (hit(w, a)) begin
                r = SEL_MWB;
            end
        end
        return r;
    endfunction

    always_comb begin
        {rs_stall_c, cmp_src_rs} = id_fwd(id_rs_use_d, id_rs, e_q, m_q, w_q);
        {rt_stall_c, cmp_src_rt} = id_fwd(id_rt_use_d, id_rt, e_q, m_q, w_q);
        lu_stall_c = (e_q.kind == K_LOAD) &&
                     ((id_rs_use_e && hit(e_q, id_rs)) || (id_rt_use_e && hit(e_q, id_rt)));
        stall      = rs_stall_c || rt_stall_c || lu_stall_c || md_stall_c;
        alu_src_rs = ex_fwd(e_rs_use_q, e_rs_q, m_q, w_q);
        alu_src_rt = ex_fwd(e_rt_use_q, e_rt_q, m_q, w_q);
        dm_src     = alu_src_rt;
    end

    // A stall turns the ID instruction into a bubble on its way into E.
    always_comb begin
        e_d        = '0;
        e_rs_d     = '0;
        e_rt_d     = '0;
        e_rs_use_d = 1'b0;
        e_rt_use_d = 1'b0;
        if (!stall) begin
            e_d.valid  = (id_wkind != '0);
            e_d.wa     = id_wa;
            e_d.kind   = id_wkind;
            e_rs_d     = id_rs;
            e_rt_d     = id_rt;
            e_rs_use_d = id_rs_use_e;
            e_rt_use_d = id_rt_use_e;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q        <= '0;
            m_q        <= '0;
            w_q        <= '0;
            e_rs_q     <= '0;
            e_rt_q     <= '0;
            e_rs_use_q <= 1'b0;
            e_rt_use_q <= 1'b0;
        end else begin
            e_q        <= e_d;
            m_q        <= e_q;
            w_q        <= m_q;
            e_rs_q     <= e_rs_d;
            e_rt_q     <= e_rt_d;
            e_rs_use_q <= e_rs_use_d;
            e_rt_use_q <= e_rt_use_d;
        end
    end

`ifdef HAZARD_MULDIV_EN
    localparam int unsigned MAX_CYC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
    localparam int unsigned CW      = $clog2(MAX_CYC + 1);

    logic [CW-1:0] md_cnt_q, md_cnt_d;

    // A start pulse always reloads, even while a previous operation is running.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (ex_md_start) begin
            md_cnt_d = ex_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= '0;
        end else begin
            md_cnt_q <= md_cnt_d;
        end
    end

    assign md_busy    = rst_n && ((md_cnt_q != '0) || ex_md_start);
    assign md_stall_c = id_md_use && md_busy;
`else
    logic unused_md;
    assign unused_md  = ^{id_md_use, ex_md_start, ex_md_div, MULT_CYC, DIV_CYC};
    assign md_busy    = 1'b0;
    assign md_stall_c = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Bench for hazard_forward_ctrl: directed vector table, reset/mult-div sequences,
// and randomized traffic checked against a pipeline-history reference model.
module tb_hazard_forward_ctrl;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic       clk;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, id_wa;
    logic       id_rs_use_d, id_rt_use_d, id_rs_use_e, id_rt_use_e;
    logic [1:0] id_wkind;
    logic       id_md_use, ex_md_start, ex_md_div;
    logic       stall, md_busy;
    logic [3:0] cmp_src_rs, cmp_src_rt, alu_src_rs, alu_src_rt, dm_src;

    hazard_forward_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_use_d(id_rs_use_d), .id_rt_use_d(id_rt_use_d),
        .id_rs_use_e(id_rs_use_e), .id_rt_use_e(id_rt_use_e),
        .id_wa(id_wa), .id_wkind(id_wkind),
        .id_md_use(id_md_use), .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
        .stall(stall),
        .cmp_src_rs(cmp_src_rs), .cmp_src_rt(cmp_src_rt),
        .alu_src_rs(alu_src_rs), .alu_src_rt(alu_src_rt),
        .dm_src(dm_src), .md_busy(md_busy)
    );

    typedef struct {
        logic [4:0] rs, rt, wa;
        logic [1:0] wk;
        logic       ud_rs, ud_rt, ue_rs, ue_rt;
        logic       md_use, md_start, md_div;
    } stim_t;

    typedef struct {
        logic       stall;
        logic [3:0] cmp_rs, cmp_rt, alu_rs, alu_rt;
        logic       md_busy;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    // One instruction that has left ID; index 0 of the history is the one in EX.
    typedef struct {
        logic [1:0] kind;
        logic [4:0] wa, rs, rt;
        logic       ue_rs, ue_rt;
    } slot_t;

    int    n_cmp = 0;
    int    n_bad = 0;
    vec_t  tbl[$];
    slot_t hist[$];
    int    cyc;
    int    md_free;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mkst(input int rs, input int rt, input int wa, input int wk,
                                   input logic [3:0] u);
        stim_t s;
        s.rs = 5'(rs); s.rt = 5'(rt); s.wa = 5'(wa); s.wk = 2'(wk);
        {s.ud_rs, s.ud_rt, s.ue_rs, s.ue_rt} = u;
        s.md_use = 1'b0; s.md_start = 1'b0; s.md_div = 1'b0;
        return s;
    endfunction

    function automatic exp_t mkexp(input int stl, input int crs, input int crt,
                                   input int ars, input int art);
        exp_t e;
        e.stall = 1'(stl); e.cmp_rs = 4'(crs); e.cmp_rt = 4'(crt);
        e.alu_rs = 4'(ars); e.alu_rt = 4'(art); e.md_busy = 1'b0;
        return e;
    endfunction

    function automatic void add(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s; v.e = e;
        tbl.push_back(v);
    endfunction

    task automatic apply(input stim_t s);
        id_rs = s.rs; id_rt = s.rt; id_wa = s.wa; id_wkind = s.wk;
        id_rs_use_d = s.ud_rs; id_rt_use_d = s.ud_rt;
        id_rs_use_e = s.ue_rs; id_rt_use_e = s.ue_rt;
        id_md_use = s.md_use; ex_md_start = s.md_start; ex_md_div = s.md_div;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".stall"},      int'(stall),      int'(e.stall));
        chk({tag, ".cmp_src_rs"}, int'(cmp_src_rs), int'(e.cmp_rs));
        chk({tag, ".cmp_src_rt"}, int'(cmp_src_rt), int'(e.cmp_rt));
        chk({tag, ".alu_src_rs"}, int'(alu_src_rs), int'(e.alu_rs));
        chk({tag, ".alu_src_rt"}, int'(alu_src_rt), int'(e.alu_rt));
        chk({tag, ".dm_src"},     int'(dm_src),     int'(e.alu_rt));
        chk({tag, ".md_busy"},    int'(md_busy),    int'(e.md_busy));
    endtask

    function automatic slot_t empty_slot();
        slot_t b;
        b.kind = '0; b.wa = '0; b.rs = '0; b.rt = '0; b.ue_rs = 1'b0; b.ue_rt = 1'b0;
        return b;
    endfunction

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 3; i++) hist.push_back(empty_slot());
        cyc = 0;
        md_free = 0;
    endfunction

    // Reader in ID: scan producers youngest first (age 0 = EX, 1 = MEM, 2 = WB).
    function automatic logic [4:0] ref_id(input logic use_d, input logic [4:0] a);
        logic [4:0] r;
        logic       found;
        r = '0;
        found = 1'b0;
        if (use_d && a != 0) begin
            for (int d = 0; d < 3; d++) begin
                if (!found && hist[d].kind != 0 && hist[d].wa == a) begin
                    found = 1'b1;
                    if (d == 0)      r = (hist[d].kind == 1) ? 5'd3 : 5'b10000;
                    else if (d == 1) r = (hist[d].kind == 3) ? 5'b10000 : 5'd1;
                    else             r = 5'd2;
                end
            end
        end
        return r;
    endfunction

    // Reader in EX: its producers are the two older instructions.
    function automatic logic [3:0] ref_ex(input logic use_e, input logic [4:0] a);
        if (!use_e || a == 0) return 4'd0;
        if (hist[1].kind != 0 && hist[1].wa == a) return (hist[1].kind == 3) ? 4'd0 : 4'd1;
        if (hist[2].kind != 0 && hist[2].wa == a) return 4'd2;
        return 4'd0;
    endfunction

    function automatic exp_t model_expect(input stim_t s);
        exp_t e;
        logic rs_stl, rt_stl, lu, md_stl;
        {rs_stl, e.cmp_rs} = ref_id(s.ud_rs, s.rs);
        {rt_stl, e.cmp_rt} = ref_id(s.ud_rt, s.rt);
        lu = (hist[0].kind == 3) && (hist[0].wa != 0) &&
             ((s.ue_rs && s.rs == hist[0].wa) || (s.ue_rt && s.rt == hist[0].wa));
`ifdef HAZARD_MULDIV_EN
        e.md_busy = (cyc < md_free) || s.md_start;
`else
        e.md_busy = 1'b0;
`endif
        md_stl = s.md_use && e.md_busy;
        e.stall  = rs_stl || rt_stl || lu || md_stl;
        e.alu_rs = ref_ex(hist[0].ue_rs, hist[0].rs);
        e.alu_rt = ref_ex(hist[0].ue_rt, hist[0].rt);
        return e;
    endfunction

    function automatic void model_step(input stim_t s, input logic stl);
        slot_t n;
        n = empty_slot();
        if (!stl) begin
            n.kind = s.wk; n.wa = s.wa; n.rs = s.rs; n.rt = s.rt;
            n.ue_rs = s.ue_rs; n.ue_rt = s.ue_rt;
        end
        hist.push_front(n);
        void'(hist.pop_back());
`ifdef HAZARD_MULDIV_EN
        if (s.md_start) md_free = cyc + 1 + int'(s.md_div ? DC : MC);
`endif
        cyc++;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t nop, s;
        exp_t  z, e;
        int    cnt;
        logic  done;

        nop = mkst(0, 0, 0, 0, 4'b0000);
        z   = mkexp(0, 0, 0, 0, 0);

        // ALU result forwarding from MEM then WB
        add(mkst(0, 0, 3, 2, 4'b0000), z);
        add(mkst(3, 0, 4, 2, 4'b0010), z);
        add(mkst(3, 0, 0, 0, 4'b0010), mkexp(0, 0, 0, 1, 0));
        add(nop,                       mkexp(0, 0, 0, 2, 0));
        // load-use: one bubble, then WB forwarding for rt / store data
        add(mkst(0, 0, 5, 3, 4'b0000), z);
        add(mkst(0, 5, 8, 2, 4'b0001), mkexp(1, 0, 0, 0, 0));
        add(mkst(0, 5, 8, 2, 4'b0001), z);
        add(nop,                       mkexp(0, 0, 0, 0, 2));
        // jal then jr $31 twice
        add(mkst(0, 0, 31, 1, 4'b0000), z);
        add(mkst(31, 0, 0, 0, 4'b1000), mkexp(0, 3, 0, 0, 0));
        add(mkst(31, 0, 0, 0, 4'b1000), mkexp(0, 1, 0, 0, 0));
        // branch on a load: two stall cycles
        add(mkst(0, 0, 7, 3, 4'b0000), z);
        add(mkst(7, 0, 0, 0, 4'b1100), mkexp(1, 0, 0, 0, 0));
        add(mkst(7, 0, 0, 0, 4'b1100), mkexp(1, 0, 0, 0, 0));
        add(mkst(7, 0, 0, 0, 4'b1100), mkexp(0, 2, 0, 0, 0));
        // writes to $0 never forward
        add(mkst(0, 0, 0, 2, 4'b0000), z);
        add(mkst(0, 0, 0, 0, 4'b1111), z);
        add(nop,                       z);
        // branch on an ALU result: one stall cycle
        add(mkst(0, 0, 9, 2, 4'b0000), z);
        add(mkst(9, 0, 0, 0, 4'b1000), mkexp(1, 0, 0, 0, 0));
        add(mkst(9, 0, 0, 0, 4'b1000), mkexp(0, 1, 0, 0, 0));
        // stalled rs shows 0 while rt still forwards
        add(mkst(0, 0, 11, 2, 4'b0000), z);
        add(mkst(0, 0, 10, 3, 4'b0000), z);
        add(mkst(10, 11, 0, 0, 4'b1100), mkexp(1, 0, 1, 0, 0));
        add(mkst(10, 11, 0, 0, 4'b1100), mkexp(1, 0, 2, 0, 0));
        add(mkst(10, 11, 0, 0, 4'b1100), mkexp(0, 2, 0, 0, 0));

        rst_n = 1'b0;
        apply(nop);
        #2;
        chk_all("reset", z);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            apply(tbl[i].s);
            #1;
            chk_all($sformatf("vec%0d", i), tbl[i].e);
        end

        // Reset asserted in the middle of a load-use stall
        repeat (3) begin
            @(negedge clk);
            apply(nop);
        end
        @(negedge clk);
        apply(mkst(0, 0, 5, 3, 4'b0000));
        @(negedge clk);
        apply(mkst(0, 5, 0, 0, 4'b0101));
        #1;
        chk("rst_mid.stall_before", int'(stall), 1);
        #1;
        rst_n = 1'b0;
        ex_md_start = 1'b1;
        #1;
        chk_all("rst_mid", z);
        ex_md_start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("rst_rel", z);
        @(negedge clk);
        apply(nop);
        #1;
        chk_all("rst_after", z);

`ifdef HAZARD_MULDIV_EN
        for (int k = 0; k < 2; k++) begin
            s = nop;
            s.md_start = 1'b1;
            s.md_div = (k == 0);
            @(negedge clk);
            apply(s);
            #1;
            chk("md.busy_on_start", int'(md_busy), 1);
            chk("md.no_stall_on_start", int'(stall), 0);
            s = nop;
            s.md_use = 1'b1;
            cnt = 0;
            done = 1'b0;
            for (int c = 0; c < 40 && !done; c++) begin
                @(negedge clk);
                apply(s);
                #1;
                if (stall) cnt++;
                else done = 1'b1;
            end
            chk((k == 0) ? "md.div_stall_len" : "md.mult_stall_len", cnt, int'((k == 0) ? DC : MC));
            chk("md.busy_after", int'(md_busy), 0);
        end
`else
        s = nop;
        s.md_use = 1'b1; s.md_start = 1'b1; s.md_div = 1'b1;
        @(negedge clk);
        apply(s);
        #1;
        chk("md_off.stall", int'(stall), 0);
        chk("md_off.busy", int'(md_busy), 0);
        s.md_start = 1'b0;
        @(negedge clk);
        apply(s);
        #1;
        chk("md_off.stall_next", int'(stall), 0);
`endif

        // Randomized traffic against the history model
        @(negedge clk);
        apply(nop);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2000; i++) begin
            s.rs = 5'($urandom_range(0, 3));
            s.rt = 5'($urandom_range(0, 3));
            s.wa = 5'($urandom_range(0, 3));
            s.wk = 2'($urandom_range(0, 3));
            s.ud_rs = 1'($urandom_range(0, 1));
            s.ud_rt = 1'($urandom_range(0, 1));
            s.ue_rs = 1'($urandom_range(0, 1));
            s.ue_rt = 1'($urandom_range(0, 1));
            s.md_use = 1'($urandom_range(0, 1));
            s.md_start = ($urandom_range(0, 9) == 0);
            s.md_div = 1'($urandom_range(0, 1));
            e = model_expect(s);
            @(negedge clk);
            apply(s);
            #1;
            chk_all($sformatf("rnd%0d", i), e);
            model_step(s, e.stall);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
